sobel_window_gen: RTL and testbench

//  Parametrised 3x3 neighbourhood generator for the Sobel pipeline; next generation of the

---
 rtl/sobel_window_gen.sv | 144 ++++++++++++++
 tb/tb_sobel_window_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// ============================================================================
// sobel_window_gen : 3x3 interior-window generator with two line buffers
// Optional: define SOBEL_WIN_COORD_EN to add centre-coordinate outputs
// Rev 1.0
// ============================================================================
`default_nettype none

module sobel_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  sof_i,
  input  logic [DATA_W-1:0]     pixel_i,
  output logic [9*DATA_W-1:0]   win_o,
  output logic                  valid_o,
  output logic                  frame_done_o
`ifdef SOBEL_WIN_COORD_EN
  ,
  output logic [$clog2(IMG_W)-1:0] col_o,
  output logic [$clog2(IMG_H)-1:0] row_o
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [DATA_W-1:0]   lb0_mem [IMG_W];
  logic [DATA_W-1:0]   lb1_mem [IMG_W];
  logic [DATA_W-1:0]   lb0_rd, lb1_rd;

  logic [CW-1:0]       col_q, col_d, cur_col;
  logic [RW-1:0]       row_q, row_d, cur_row;
  logic [2*DATA_W-1:0] top_q, top_d, mid_q, mid_d, bot_q, bot_d;
  logic [9*DATA_W-1:0] win_q, win_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
`ifdef SOBEL_WIN_COORD_EN
  logic [CW-1:0]       ccol_q, ccol_d;
  logic [RW-1:0]       crow_q, crow_d;
`endif

  always_comb begin
    cur_col = sof_i ? '0 : col_q;
    cur_row = sof_i ? '0 : row_q;
    lb0_rd  = lb0_mem[cur_col];
    lb1_rd  = lb1_mem[cur_col];

    col_d   = col_q;
    row_d   = row_q;
    top_d   = top_q;
    mid_d   = mid_q;
    bot_d   = bot_q;
    win_d   = win_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
`ifdef SOBEL_WIN_COORD_EN
    ccol_d  = ccol_q;
    crow_d  = crow_q;
`endif

    if (valid_i) begin
      // Taps keep the two previous columns; the low half is the older one.
      top_d = {lb0_rd,  top_q[2*DATA_W-1:DATA_W]};
      mid_d = {lb1_rd,  mid_q[2*DATA_W-1:DATA_W]};
      bot_d = {pixel_i, bot_q[2*DATA_W-1:DATA_W]};

      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end

      done_d = (cur_col == COL_LAST) && (cur_row == ROW_LAST);

      if ((cur_col >= COL_TWO) && (cur_row >= ROW_TWO)) begin
        valid_d = 1'b1;
        win_d   = {pixel_i, bot_q, lb1_rd, mid_q, lb0_rd, top_q};
`ifdef SOBEL_WIN_COORD_EN
        ccol_d  = cur_col - CW'(1);
        crow_d  = cur_row - RW'(1);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      top_q   <= '0;
      mid_q   <= '0;
      bot_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef SOBEL_WIN_COORD_EN
      ccol_q  <= '0;
      crow_q  <= '0;
`endif
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      top_q   <= top_d;
      mid_q   <= mid_d;
      bot_q   <= bot_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef SOBEL_WIN_COORD_EN
      ccol_q  <= ccol_d;
      crow_q  <= crow_d;
`endif
    end
  end

  // Line-buffer contents are never emitted before being rewritten, so no reset.
  always_ff @(posedge clk) begin
    if (valid_i && !rst) begin
      lb1_mem[cur_col] <= pixel_i;
      lb0_mem[cur_col] <= lb1_rd;
    end
  end

  assign win_o        = win_q;
  assign valid_o      = valid_q;
  assign frame_done_o = done_q;
`ifdef SOBEL_WIN_COORD_EN
  assign col_o        = ccol_q;
  assign row_o        = crow_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: 4x4 frames, image-model scoreboard of expected windows.
`default_nettype none

module tb_sobel_window_gen;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_i = 1'b0;
  logic          sof_i = 1'b0;
  logic [DW-1:0] pixel_i = '0;
  logic [9*DW-1:0] win_o;
  logic          valid_o;
  logic          frame_done_o;
`ifdef SOBEL_WIN_COORD_EN
  logic [1:0]    col_o;
  logic [1:0]    row_o;
`endif

  always #5 clk = ~clk;

  sobel_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .sof_i        (sof_i),
    .pixel_i      (pixel_i),
    .win_o        (win_o),
    .valid_o      (valid_o),
    .frame_done_o (frame_done_o)
`ifdef SOBEL_WIN_COORD_EN
    ,
    .col_o        (col_o),
    .row_o        (row_o)
`endif
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [71:0]   win_sb[$];
  logic [3:0]    coord_sb[$];
  logic [7:0]    img [H][W];
  int            mc = 0;
  int            mr = 0;
  logic          exp_v;
  logic          exp_fd;
  logic [71:0]   last_win = '0;
  logic [71:0]   first_win = '0;
  int            n_win = 0;
  int            n_done = 0;

  task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [7:0] pix);
    logic [71:0] w;
    exp_v  = 1'b0;
    exp_fd = 1'b0;
    if (v) begin
      if (s) begin
        mc = 0;
        mr = 0;
      end
      img[mr][mc] = pix;
      if (mc >= 2 && mr >= 2) begin
        w = '0;
        for (int dy = 0; dy < 3; dy++)
          for (int dx = 0; dx < 3; dx++)
            w[(dy*3+dx)*8 +: 8] = img[mr-2+dy][mc-2+dx];
        win_sb.push_back(w);
        coord_sb.push_back({2'(mr-1), 2'(mc-1)});
        exp_v = 1'b1;
      end
      exp_fd = (mc == W-1) && (mr == H-1);
      if (mc == W-1) begin
        mc = 0;
        mr = (mr == H-1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
    valid_i = v;
    sof_i   = s;
    pixel_i = pix;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    sof_i   = 1'b0;
    check_val("valid_o", 72'(valid_o), 72'(exp_v));
    check_val("frame_done_o", 72'(frame_done_o), 72'(exp_fd));
    if (frame_done_o) n_done++;
    if (valid_o) begin
      n_win++;
      check_val("sb_nonempty", 72'(win_sb.size() != 0), 72'd1);
      if (win_sb.size() != 0) begin
        last_win = win_sb.pop_front();
        check_val("win_o", win_o, last_win);
        if (n_win == 1) first_win = win_o;
`ifdef SOBEL_WIN_COORD_EN
        check_val("coord", 72'({row_o, col_o}), 72'(coord_sb[0]));
`endif
        void'(coord_sb.pop_front());
      end
    end else begin
      check_val("win_hold", win_o, last_win);
    end
  endtask

  task automatic do_reset(input logic v_during);
    rst     = 1'b1;
    valid_i = v_during;
    pixel_i = 8'hEE;
    @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    valid_i = 1'b0;
    mc = 0;
    mr = 0;
    last_win = '0;
    win_sb.delete();
    coord_sb.delete();
    check_val("rst_win", win_o, 72'd0);
    check_val("rst_valid", 72'(valid_o), 72'd0);
    check_val("rst_done", 72'(frame_done_o), 72'd0);
  endtask

  task automatic run_frame(input int offset, input logic first_sof, input logic gaps);
    for (int i = 0; i < W*H; i++) begin
      step(1'b1, first_sof && (i == 0), 8'(i + offset));
      if (gaps) step(1'b0, 1'b0, 8'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    do_reset(1'b0);

    // Continuous frame
    n_win = 0; n_done = 0;
    run_frame(0, 1'b1, 1'b0);
    check_val("t1_windows", 72'(n_win), 72'd4);
    check_val("t1_done", 72'(n_done), 72'd1);
    check_val("t1_first", first_win, 72'h0a0908060504020100);
    check_val("t1_last", last_win, 72'h0f0e0d0b0a09070605);

    // Gapped frame, invalid cycles carry junk pixels
    n_win = 0; n_done = 0;
    run_frame(0, 1'b1, 1'b1);
    check_val("t2_windows", 72'(n_win), 72'd4);
    check_val("t2_done", 72'(n_done), 72'd1);
    check_val("t2_first", first_win, 72'h0a0908060504020100);

    // Back-to-back frames, second one via natural wrap
    run_frame(0, 1'b1, 1'b0);
    n_win = 0; n_done = 0;
    run_frame(100, 1'b0, 1'b0);
    check_val("t3_windows", 72'(n_win), 72'd4);
    check_val("t3_done", 72'(n_done), 72'd1);
    check_val("t3_first", first_win, 72'h6e6d6c6a6968666564);

    // SOF abandons a partial frame at pixel 6
    n_win = 0; n_done = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(50 + i));
    check_val("t4_partial_done", 72'(n_done), 72'd0);
    run_frame(200, 1'b1, 1'b0);
    check_val("t4_windows", 72'(n_win), 72'd4);
    check_val("t4_done", 72'(n_done), 72'd1);

    // Reset in the middle of row 2, with a valid pixel during reset
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(30 + i));
    do_reset(1'b1);
    n_win = 0; n_done = 0;
    run_frame(0, 1'b0, 1'b0);
    check_val("t5_windows", 72'(n_win), 72'd4);
    check_val("t5_done", 72'(n_done), 72'd1);
    check_val("t5_first", first_win, 72'h0a0908060504020100);
    check_val("sb_drained", 72'(win_sb.size()), 72'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
